core_sequencer: RTL

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_pkg.sv | 42 ++++
 rtl/seq_wait_timer.sv | 49 ++++
 rtl/core_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: FSM state encodings,
// RV32I major opcodes and write-back source selects.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5,
    ST_TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  // State that follows DECODE for a given opcode; unknown opcodes trap.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: nxt = ST_EXECUTE;
      OPC_SYSTEM:                            nxt = ST_HALT;
      default:                               nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive wait cycles of a handshake and flags the cycle in
// which the count has reached TIMEOUT without an acknowledge.
module seq_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count only while waiting; any other cycle (ack, other state) clears it,
  // so the count is zero on every fresh entry into a waiting state.
  always_comb begin
    cnt_d = '0;
    if (active_i && !ack_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the limit cycle takes priority over the timeout.
  always_comb begin
    timeout_o = 1'b0;
    if (active_i && !ack_i && (cnt_q == TIMEOUT_C)) begin
      timeout_o = 1'b1;
    end else begin
      timeout_o = 1'b0;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with sticky
// HALT and TRAP states, handshake timeouts and a retired-instruction count.
module core_sequencer
  import core_pkg::*;
#(
  parameter int N_param = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode_i,
  input  logic               imem_ack_i,
  input  logic               dmem_ack_i,
  input  logic               branch_taken_i,
  output logic               imem_req_o,
  output logic               ir_load_o,
  output logic               alu_en_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic               reg_we_o,
  output logic [1:0]         wb_sel_o,
  output logic               pc_en_o,
  output logic               pc_sel_o,
  output logic [2:0]         state_o,
  output logic               halted_o,
  output logic               trap_o,
  output logic [N_param-1:0] instret_o
);

  state_t             state_q;
  logic [6:0]         op_q;
  logic [N_param-1:0] instret_q;

  logic wait_active_s;
  logic wait_ack_s;
  logic timeout_s;
  logic retire_s;

  // Select which handshake the wait timer is watching.
  always_comb begin
    wait_active_s = 1'b0;
    wait_ack_s    = 1'b0;
    if (state_q == ST_FETCH) begin
      wait_active_s = 1'b1;
      wait_ack_s    = imem_ack_i;
    end else if (state_q == ST_MEM) begin
      wait_active_s = 1'b1;
      wait_ack_s    = dmem_ack_i;
    end else begin
      wait_active_s = 1'b0;
      wait_ack_s    = 1'b0;
    end
  end

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active_i  (wait_active_s),
    .ack_i     (wait_ack_s),
    .timeout_o (timeout_s)
  );

  // State register, opcode capture and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      op_q      <= 7'b0000000;
      instret_q <= '0;
    end else begin
      if (retire_s) begin
        instret_q <= instret_q + N_param'(1);
      end
      case (state_q)
        ST_FETCH: begin
          if (imem_ack_i) begin
            state_q <= ST_DECODE;
          end else if (timeout_s) begin
            state_q <= ST_TRAP;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          op_q    <= opcode_i;
          state_q <= decode_next(opcode_i);
        end
        ST_EXECUTE: begin
          if ((op_q == OPC_LOAD) || (op_q == OPC_STORE)) begin
            state_q <= ST_MEM;
          end else if (op_q == OPC_BRANCH) begin
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack_i) begin
            state_q <= (op_q == OPC_STORE) ? ST_FETCH : ST_WB;
          end else if (timeout_s) begin
            state_q <= ST_TRAP;
          end else begin
            state_q <= ST_MEM;
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  // Output decode; handshake responses must be visible in the same cycle
  // as the ack, and everything is forced low while reset is asserted.
  always_comb begin
    imem_req_o = 1'b0;
    ir_load_o  = 1'b0;
    alu_en_o   = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    reg_we_o   = 1'b0;
    wb_sel_o   = WB_SEL_ALU;
    pc_en_o    = 1'b0;
    pc_sel_o   = 1'b0;
    halted_o   = 1'b0;
    trap_o     = 1'b0;
    retire_s   = 1'b0;
    if (reset) begin
      retire_s = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          imem_req_o = 1'b1;
          ir_load_o  = imem_ack_i;
        end
        ST_DECODE: begin
          retire_s = 1'b0;
        end
        ST_EXECUTE: begin
          alu_en_o = 1'b1;
          if (op_q == OPC_BRANCH) begin
            pc_en_o  = 1'b1;
            pc_sel_o = branch_taken_i;
            retire_s = 1'b1;
          end else begin
            retire_s = 1'b0;
          end
        end
        ST_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (op_q == OPC_STORE);
          if ((op_q == OPC_STORE) && dmem_ack_i) begin
            pc_en_o  = 1'b1;
            retire_s = 1'b1;
          end else begin
            retire_s = 1'b0;
          end
        end
        ST_WB: begin
          reg_we_o = 1'b1;
          pc_en_o  = 1'b1;
          retire_s = 1'b1;
          if (op_q == OPC_LOAD) begin
            wb_sel_o = WB_SEL_LOAD;
          end else if ((op_q == OPC_JAL) || (op_q == OPC_JALR)) begin
            wb_sel_o = WB_SEL_PC4;
            pc_sel_o = 1'b1;
          end else begin
            wb_sel_o = WB_SEL_ALU;
          end
        end
        ST_HALT: halted_o = 1'b1;
        ST_TRAP: trap_o   = 1'b1;
        default: trap_o   = 1'b0;
      endcase
    end
  end

  assign state_o   = reset ? 3'd0 : state_q;
  assign instret_o = reset ? '0 : instret_q;

endmodule
